// File: rtl/md_seq.sv
// Multi-cycle multiply/divide unit with HI/LO registers, abort and snapshot rollback.
// state | meaning
// IDLE  | accepts ops; mthi/mtlo and mfhi/mflo take effect immediately
// RUN   | multi-cycle op in flight; result commits when cnt reaches 1
module md_seq #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dh,
    input  logic [WIDTH-1:0] dl,
    input  logic [3:0]       op,
    input  logic             stop,
    input  logic             restore,
    output logic             busy,
    output logic             invalid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] out
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    logic [0:0]         state;
    logic [4:0]         cnt;
    logic [WIDTH-1:0]   hi_q, lo_q, snap_hi, snap_lo, rhi, rlo;

    logic [2*WIDTH-1:0] acc, prod_s, prod_u;
    logic [WIDTH-1:0]   mag_a, mag_b, uq, ur, res_hi, res_lo;
    logic               is_mul, is_div;

    assign busy    = (state == ST_RUN);
    assign invalid = (op >= 4'd13) || ((op != 4'd0) && busy);
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign out     = (op == OP_MFHI) ? hi_q : (op == OP_MFLO) ? lo_q : '0;

    // Low 2*WIDTH bits of the extended product are exact for both signednesses.
    assign acc    = {hi_q, lo_q};
    assign prod_s = {{WIDTH{dh[WIDTH-1]}}, dh} * {{WIDTH{dl[WIDTH-1]}}, dl};
    assign prod_u = {{WIDTH{1'b0}}, dh} * {{WIDTH{1'b0}}, dl};

    // Magnitude divide; most-negative / -1 wraps back to most-negative with zero remainder.
    assign mag_a = dh[WIDTH-1] ? (~dh + 1'b1) : dh;
    assign mag_b = dl[WIDTH-1] ? (~dl + 1'b1) : dl;
    assign uq    = (mag_b == '0) ? '0 : mag_a / mag_b;
    assign ur    = (mag_b == '0) ? '0 : mag_a % mag_b;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        is_mul = 1'b0;
        is_div = 1'b0;
        case (op)
            OP_MULT:  begin is_mul = 1'b1; {res_hi, res_lo} = prod_s; end
            OP_MULTU: begin is_mul = 1'b1; {res_hi, res_lo} = prod_u; end
            OP_MADD:  begin is_mul = 1'b1; {res_hi, res_lo} = acc + prod_s; end
            OP_MADDU: begin is_mul = 1'b1; {res_hi, res_lo} = acc + prod_u; end
            OP_MSUB:  begin is_mul = 1'b1; {res_hi, res_lo} = acc - prod_s; end
            OP_MSUBU: begin is_mul = 1'b1; {res_hi, res_lo} = acc - prod_u; end
            OP_DIV: begin
                is_div = 1'b1;
                if (dl == '0) begin
                    res_hi = dh;
                    res_lo = '1;
                end else begin
                    res_lo = (dh[WIDTH-1] ^ dl[WIDTH-1]) ? (~uq + 1'b1) : uq;
                    res_hi = dh[WIDTH-1] ? (~ur + 1'b1) : ur;
                end
            end
            OP_DIVU: begin
                is_div = 1'b1;
                if (dl == '0) begin
                    res_hi = dh;
                    res_lo = '1;
                end else begin
                    res_lo = dh / dl;
                    res_hi = dh % dl;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            snap_hi <= '0;
            snap_lo <= '0;
            rhi     <= '0;
            rlo     <= '0;
        end else if (state == ST_RUN) begin
            if (restore) begin
                hi_q  <= snap_hi;
                lo_q  <= snap_lo;
                state <= ST_IDLE;
                cnt   <= '0;
            end else if (stop) begin
                state <= ST_IDLE;
                cnt   <= '0;
            end else if (cnt == 5'd1) begin
                hi_q  <= rhi;
                lo_q  <= rlo;
                state <= ST_IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt - 5'd1;
            end
        end else if (restore) begin
            hi_q <= snap_hi;
            lo_q <= snap_lo;
        end else if (!stop && !invalid) begin
            if (is_mul || is_div) begin
                snap_hi <= hi_q;
                snap_lo <= lo_q;
                rhi     <= res_hi;
                rlo     <= res_lo;
                cnt     <= is_mul ? 5'(MULT_CYCLES) : 5'(DIV_CYCLES);
                state   <= ST_RUN;
            end else if (op == OP_MTHI) begin
                snap_hi <= hi_q;
                snap_lo <= lo_q;
                hi_q    <= dh;
            end else if (op == OP_MTLO) begin
                snap_hi <= hi_q;
                snap_lo <= lo_q;
                lo_q    <= dh;
            end
        end
    end

endmodule
